// File: rtl/baccarat_fsm_if.sv
// Sequencer <-> datapath bundle: card load strobes, hand scores and result lights.
// master = dealing sequencer, slave = card/score datapath.
interface baccarat_fsm_if;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [3:0] pcard3;
    logic       load_pcard1;
    logic       load_pcard2;
    logic       load_pcard3;
    logic       load_dcard1;
    logic       load_dcard2;
    logic       load_dcard3;
    logic       player_win_light;
    logic       dealer_win_light;
    logic       hand_done;

    modport master (
        input  pscore, dscore, pcard3,
        output load_pcard1, load_pcard2, load_pcard3,
        output load_dcard1, load_dcard2, load_dcard3,
        output player_win_light, dealer_win_light, hand_done
    );

    modport slave (
        output pscore, dscore, pcard3,
        input  load_pcard1, load_pcard2, load_pcard3,
        input  load_dcard1, load_dcard2, load_dcard3,
        input  player_win_light, dealer_win_light, hand_done
    );
endinterface

// File: rtl/baccarat_fsm.sv
// Baccarat dealing sequencer: one state step per slow_clock edge; third-card rules under BACCARAT_THIRD_CARD_EN.
// Latency: strobes/hand_done registered from state; win lights combinational on scores while DONE.
// Backpressure: none -- the datapath must settle scores one cycle after each load.
module baccarat_fsm (
    input  logic           slow_clock,
    input  logic           reset,
    baccarat_fsm_if.master bus
);
    typedef enum logic [3:0] {
        DEAL_P1 = 4'd0,
        DEAL_D1 = 4'd1,
        DEAL_P2 = 4'd2,
        DEAL_D2 = 4'd3,
        EVAL_P  = 4'd4,
        DEAL_P3 = 4'd5,
        EVAL_D  = 4'd6,
        DEAL_D3 = 4'd7,
        DONE    = 4'd8
    } state_t;

    state_t state_q, state_d;
    logic   load_pcard1_q, load_pcard1_d;
    logic   load_pcard2_q, load_pcard2_d;
    logic   load_pcard3_q, load_pcard3_d;
    logic   load_dcard1_q, load_dcard1_d;
    logic   load_dcard2_q, load_dcard2_d;
    logic   load_dcard3_q, load_dcard3_d;
    logic   hand_done_q,   hand_done_d;

`ifdef BACCARAT_THIRD_CARD_EN
    logic       natural;
    logic       dealer_draw;
    logic [3:0] pcard3_val;

    always_comb begin
        // Scores of 10-15 are out of contract and fall on the natural path.
        natural    = (bus.pscore >= 4'd8) || (bus.dscore >= 4'd8);
        pcard3_val = (bus.pcard3 >= 4'd10) ? 4'd0 : bus.pcard3;
        dealer_draw = 1'b0;
        case (bus.dscore)
            4'd0, 4'd1, 4'd2: dealer_draw = 1'b1;
            4'd3:             dealer_draw = (pcard3_val != 4'd8);
            4'd4:             dealer_draw = (pcard3_val >= 4'd2) && (pcard3_val <= 4'd7);
            4'd5:             dealer_draw = (pcard3_val >= 4'd4) && (pcard3_val <= 4'd7);
            4'd6:             dealer_draw = (pcard3_val == 4'd6) || (pcard3_val == 4'd7);
            default:          dealer_draw = 1'b0;
        endcase
    end
`endif

    always_comb begin
        state_d = DEAL_P1;
        case (state_q)
            DEAL_P1: state_d = DEAL_D1;
            DEAL_D1: state_d = DEAL_P2;
            DEAL_P2: state_d = DEAL_D2;
            DEAL_D2: state_d = EVAL_P;
`ifdef BACCARAT_THIRD_CARD_EN
            EVAL_P: begin
                if (natural)                    state_d = DONE;
                else if (bus.pscore <= 4'd5)    state_d = DEAL_P3;
                else if (bus.dscore <= 4'd5)    state_d = DEAL_D3;
                else                            state_d = DONE;
            end
            DEAL_P3: state_d = EVAL_D;
            EVAL_D:  state_d = dealer_draw ? DEAL_D3 : DONE;
            DEAL_D3: state_d = DONE;
`else
            EVAL_P:  state_d = DONE;
`endif
            DONE:    state_d = DONE;
            default: state_d = DEAL_P1;
        endcase

        // Outputs follow the next state so they come straight off flops.
        load_pcard1_d = (state_d == DEAL_P1);
        load_dcard1_d = (state_d == DEAL_D1);
        load_pcard2_d = (state_d == DEAL_P2);
        load_dcard2_d = (state_d == DEAL_D2);
`ifdef BACCARAT_THIRD_CARD_EN
        load_pcard3_d = (state_d == DEAL_P3);
        load_dcard3_d = (state_d == DEAL_D3);
`else
        load_pcard3_d = 1'b0;
        load_dcard3_d = 1'b0;
`endif
        hand_done_d   = (state_d == DONE);
    end

    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            state_q       <= DEAL_P1;
            load_pcard1_q <= 1'b1;
            load_pcard2_q <= 1'b0;
            load_pcard3_q <= 1'b0;
            load_dcard1_q <= 1'b0;
            load_dcard2_q <= 1'b0;
            load_dcard3_q <= 1'b0;
            hand_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_pcard1_q <= load_pcard1_d;
            load_pcard2_q <= load_pcard2_d;
            load_pcard3_q <= load_pcard3_d;
            load_dcard1_q <= load_dcard1_d;
            load_dcard2_q <= load_dcard2_d;
            load_dcard3_q <= load_dcard3_d;
            hand_done_q   <= hand_done_d;
        end
    end

    assign bus.load_pcard1      = load_pcard1_q;
    assign bus.load_pcard2      = load_pcard2_q;
    assign bus.load_pcard3      = load_pcard3_q;
    assign bus.load_dcard1      = load_dcard1_q;
    assign bus.load_dcard2      = load_dcard2_q;
    assign bus.load_dcard3      = load_dcard3_q;
    assign bus.hand_done        = hand_done_q;
    assign bus.player_win_light = hand_done_q && (bus.pscore >= bus.dscore);
    assign bus.dealer_win_light = hand_done_q && (bus.dscore >= bus.pscore);
endmodule

// File: tb/tb_baccarat_fsm.sv
// Bench for baccarat_fsm: directed test-plan hands plus random hands against a rules-level hand model.
// Honours BACCARAT_THIRD_CARD_EN the same way the design does.
module tb_baccarat_fsm;
    logic slow_clock;
    logic reset;
    baccarat_fsm_if bus ();

    baccarat_fsm dut (
        .slow_clock (slow_clock),
        .reset      (reset),
        .bus        (bus)
    );

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Phases of a hand as seen by the bench's model.
    localparam int PH_P1 = 0, PH_D1 = 1, PH_P2 = 2, PH_D2 = 3, PH_EP = 4;
    localparam int PH_P3 = 5, PH_ED = 6, PH_D3 = 7, PH_DONE = 8;

    // Dealer third-card table: draw when the player's third-card value is in the allowed set.
    function automatic bit dealer_takes(input int d, input int v);
        bit allowed [0:9];
        for (int i = 0; i < 10; i++) allowed[i] = 1'b0;
        if (d <= 2) return 1'b1;
        if (d >= 7) return 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (d == 3) allowed[i] = (i != 8);
            if (d == 4) allowed[i] = (i >= 2 && i <= 7);
            if (d == 5) allowed[i] = (i >= 4 && i <= 7);
            if (d == 6) allowed[i] = (i == 6 || i == 7);
        end
        return allowed[v];
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge slow_clock);
        #1;
        @(negedge slow_clock);
        reset = 1'b0;
    endtask

    // Plays one hand: p4/d4 are the 4-card scores, p5 the player score after
    // the third card, pf/df the final scores shown in DONE.
    task automatic run_hand(input string nm, input int p4, input int d4, input int pc3,
                            input int p5, input int pf, input int df, input int exp_edges);
        int  phases[$];
        bit  pdraw, ddraw;
        int  v, first_done, want_edges;
        logic [5:0] exp_ld, got_ld;
        logic [1:0] exp_lt, got_lt;
        logic       exp_hd;
        pdraw = 1'b0;
        ddraw = 1'b0;
        want_edges = exp_edges;
        v = (pc3 >= 10) ? 0 : pc3;
`ifdef BACCARAT_THIRD_CARD_EN
        if (!(p4 >= 8 || d4 >= 8)) begin
            if (p4 <= 5) begin
                pdraw = 1'b1;
                ddraw = dealer_takes(d4, v);
            end else begin
                ddraw = (d4 <= 5);
            end
        end
`else
        if (exp_edges > 0) want_edges = 5;
`endif
        phases = '{PH_P1, PH_D1, PH_P2, PH_D2, PH_EP};
        if (pdraw) begin
            phases.push_back(PH_P3);
            phases.push_back(PH_ED);
        end
        if (ddraw) phases.push_back(PH_D3);
        repeat (3) phases.push_back(PH_DONE);

        bus.pscore = 4'(p4);
        bus.dscore = 4'(d4);
        bus.pcard3 = 4'(pc3);
        apply_reset();
        first_done = -1;
        for (int k = 0; k < phases.size(); k++) begin
            if (phases[k] == PH_DONE) begin
                bus.pscore = 4'(pf);
                bus.dscore = 4'(df);
            end else if (phases[k] == PH_ED) begin
                bus.pscore = 4'(p5);
                bus.dscore = 4'(d4);
            end else begin
                bus.pscore = 4'(p4);
                bus.dscore = 4'(d4);
            end
            #1;
            exp_ld = {phases[k] == PH_P1, phases[k] == PH_P2, phases[k] == PH_P3,
                      phases[k] == PH_D1, phases[k] == PH_D2, phases[k] == PH_D3};
            exp_hd = (phases[k] == PH_DONE);
            if (!exp_hd)       exp_lt = 2'b00;
            else if (pf > df)  exp_lt = 2'b10;
            else if (df > pf)  exp_lt = 2'b01;
            else               exp_lt = 2'b11;
            got_ld = {bus.load_pcard1, bus.load_pcard2, bus.load_pcard3,
                      bus.load_dcard1, bus.load_dcard2, bus.load_dcard3};
            got_lt = {bus.player_win_light, bus.dealer_win_light};
            n_cmp++;
            if ({got_ld, got_lt, bus.hand_done} !== {exp_ld, exp_lt, exp_hd}) begin
                n_bad++;
                $display("FAIL %s edge%0d: loads=%b lights=%b done=%b, required loads=%b lights=%b done=%b",
                         nm, k, got_ld, got_lt, bus.hand_done, exp_ld, exp_lt, exp_hd);
            end
            if (bus.hand_done === 1'b1 && first_done < 0) first_done = k;
            @(posedge slow_clock);
            #1;
        end
        if (want_edges > 0) begin
            n_cmp++;
            if (first_done != want_edges) begin
                n_bad++;
                $display("FAIL %s done_edge: got %0d, required %0d", nm, first_done, want_edges);
            end
        end
    endtask

    task automatic test_reset();
        bus.pscore = 4'd5;
        bus.dscore = 4'd5;
        bus.pcard3 = 4'd1;
        reset = 1'b1;
        #3;
        n_cmp++;
        if ({bus.load_pcard1, bus.load_pcard2, bus.load_pcard3, bus.load_dcard1, bus.load_dcard2,
             bus.load_dcard3, bus.player_win_light, bus.dealer_win_light, bus.hand_done} !== 9'b100000000) begin
            n_bad++;
            $display("FAIL reset_state: got p1..d3,lights,done=%b%b%b%b%b%b%b%b%b, required 100000000",
                     bus.load_pcard1, bus.load_pcard2, bus.load_pcard3, bus.load_dcard1, bus.load_dcard2,
                     bus.load_dcard3, bus.player_win_light, bus.dealer_win_light, bus.hand_done);
        end
        @(negedge slow_clock);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        run_hand("natural",          8, 3, 5,  0, 8, 3, 5);
        run_hand("both_draw",        4, 5, 6,  0, 0, 9, 8);
        run_hand("player_stands",    7, 4, 1,  7, 7, 7, 6);
        run_hand("dealer_face_stand",2, 6, 13, 2, 2, 6, 7);
        run_hand("d3_v8_stand",      1, 3, 8,  9, 9, 3, 7);
        run_hand("d3_v9_draw",       1, 3, 9,  0, 0, 4, 8);
        run_hand("d7_never",         0, 7, 6,  6, 6, 7, 7);
        run_hand("dealer_natural",   3, 9, 2,  3, 3, 9, 5);
        run_hand("out_of_contract", 12, 3, 4,  0, 12, 3, 5);
        run_hand("player_stand_d6",  6, 6, 2,  6, 6, 6, 5);
    endtask

    task automatic test_mid_reset();
        logic [3:0] got;
        bus.pscore = 4'd4;
        bus.dscore = 4'd5;
        bus.pcard3 = 4'd6;
        apply_reset();
        repeat (5) @(posedge slow_clock);
        bus.pscore = 4'd3;
        bus.dscore = 4'd1;
        @(negedge slow_clock);
        reset = 1'b1;
        #1;
        got = {bus.load_pcard1, bus.player_win_light, bus.dealer_win_light, bus.hand_done};
        n_cmp++;
        if (got !== 4'b1000) begin
            n_bad++;
            $display("FAIL mid_reset: got p1,lights,done=%b, required 1000", got);
        end
        reset = 1'b0;
        run_hand("after_reset", 3, 7, 5, 4, 4, 7, 7);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_hand("random", int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                     int'($urandom_range(1, 13)), int'($urandom_range(0, 9)),
                     int'($urandom_range(0, 9)), int'($urandom_range(0, 9)), 0);
        end
    endtask

    task automatic test_back_to_back();
        run_hand("b2b_a", 5, 2, 10, 5, 5, 5, 8);
        run_hand("b2b_b", 9, 9, 3,  9, 9, 9, 5);
    endtask

    initial begin
        reset = 1'b1;
        bus.pscore = 4'd0;
        bus.dscore = 4'd0;
        bus.pcard3 = 4'd1;
        test_reset();
        test_directed();
        test_mid_reset();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/baccarat_fsm.md
# baccarat_fsm

Dealing sequencer for one hand of Baccarat on the DE1-SoC. It drives the load strobes of the six card registers in the datapath: player cards 1-3 and dealer cards 1-3, each shown on a card7seg display. It reads back the hand scores and applies the third-card rules. At the end of the hand it lights the winner LEDs. One state transition occurs per `slow_clock` edge, which is a debounced key press.

## Interface
Parameters:
- none

Ports:
- `slow_clock`  in  1  sole clock; all state changes on its rising edge
- `reset`  in  1  asynchronous, active-high; forces `DEAL_P1`
- `pscore`  in  4  player hand score from the datapath, 0-9, combinational from the card registers
- `dscore`  in  4  dealer hand score from the datapath, 0-9
- `pcard3`  in  4  raw player third card, 1-13 (A..K)
- `load_pcard1`, `load_pcard2`, `load_pcard3`  out  1 each  player card register load enables
- `load_dcard1`, `load_dcard2`, `load_dcard3`  out  1 each  dealer card register load enables
- `player_win_light`  out  1  player wins, or tie
- `dealer_win_light`  out  1  dealer wins, or tie
- `hand_done`  out  1  high while in `DONE`

## Operation
- Moore FSM with states `DEAL_P1`, `DEAL_D1`, `DEAL_P2`, `DEAL_D2`, `EVAL_P`, `DEAL_P3`, `EVAL_D`, `DEAL_D3`, `DONE`.
- Each `DEAL_xn` state asserts exactly its own load strobe. The register captures on the edge that leaves the state.
- Fixed sequence: `DEAL_P1` -> `DEAL_D1` -> `DEAL_P2` -> `DEAL_D2` -> `EVAL_P`.
- `EVAL_P` (the scores reflect 4 cards):
  - `pscore` >= 8 or `dscore` >= 8 (natural) -> `DONE`
  - else `pscore` <= 5 -> `DEAL_P3`
  - else, player stands on 6/7: `dscore` <= 5 -> `DEAL_D3`, otherwise -> `DONE`
- `DEAL_P3` -> `EVAL_D`.
- `EVAL_D`: the value of the third player card is v = (`pcard3` >= 10) ? 0 : `pcard3`. The dealer draws when any of these holds:
  - `dscore` <= 2
  - `dscore` = 3 and v != 8
  - `dscore` = 4 and v in 2..7
  - `dscore` = 5 and v in 4..7
  - `dscore` = 6 and v in 6..7

  If the dealer draws -> `DEAL_D3`, otherwise -> `DONE`.
- `DEAL_D3` -> `DONE`.
- `DONE` is absorbing until `reset`.
- Win lights are combinational and valid only in `DONE`:
  - `pscore` > `dscore`: player light only
  - `dscore` > `pscore`: dealer light only
  - equal: both lights

  Outside `DONE` both lights are 0.
- Scores are compared as 4-bit unsigned values. Inputs of 10-15 are out of contract, but they must still take a defined path: they count as >= 8, i.e. natural.
- Any illegal state encoding -> `DEAL_P1` on the next edge.

## Timing
- Reset values: state `DEAL_P1`, so `load_pcard1`=1 and every other load, both lights and `hand_done` are 0. The datapath is held in reset concurrently, so the asserted strobe is harmless.
- All outputs are decoded from the registered state, with no input-to-load path. The lights depend combinationally on the scores.
- `hand_done` first rises:
  - 5 edges after reset release for a natural or an early stand
  - 6 edges when only the dealer draws
  - 7 edges when only the player draws
  - 8 edges for a full six-card hand
- Exactly one load strobe is high in any `DEAL_*` state. None is high in `EVAL_*` or `DONE`. No card register is loaded twice per hand.
- The `EVAL_*` decisions sample the scores on the edge that leaves the state. The scores must be settled one cycle after the preceding load.
- Reset mid-hand, in any state: immediate async return to `DEAL_P1` with the lights cleared. There is no partial-hand memory.

## Configuration
- `BACCARAT_THIRD_CARD_EN` defined: the full third-card rules above apply.
- Not defined:
  - `EVAL_P` always -> `DONE`.
  - `DEAL_P3`, `EVAL_D` and `DEAL_D3` are unreachable and may be removed.
  - `load_pcard3` and `load_dcard3` are tied to 0.
  - `hand_done` rises 5 edges after reset.

## Test plan
- Natural: `pscore`=8, `dscore`=3 at `EVAL_P` -> `DONE` after 5 edges, `player_win_light`=1, `dealer_win_light`=0; `load_pcard3` and `load_dcard3` never pulse.
- Both draw: `pscore`=4, `dscore`=5, `pcard3`=6 -> `load_pcard3` pulses in edge interval 5-6 and `load_dcard3` in 7-8. With final `pscore`=0 and `dscore`=9, `dealer_win_light`=1.
- Player stands: `pscore`=7, `dscore`=4 -> `DEAL_D3` directly, with no `load_pcard3`. With final `dscore`=7, both lights are 1 (tie).
- Dealer stands on a face card: `pscore`=2, `dscore`=6, `pcard3`=13 (v=0) -> `load_pcard3` pulses and `load_dcard3` does not. `hand_done` rises at edge 7.
- Boundary values:
  - `dscore`=3, `pcard3`=8 -> no dealer draw
  - `dscore`=3, `pcard3`=9 -> draw
  - `dscore`=7 -> never draws
- Reset in `DEAL_P3`: assert `reset` mid-cycle -> `load_pcard1`=1 immediately, the lights are 0, and the sequence restarts from P1. Built without `BACCARAT_THIRD_CARD_EN`, `pscore`=3 -> `DONE` at edge 5.
